stack_ptr_unit: RTL and testbench

- Owns the data-stack pointer (DP) and return-stack pointer (RP) for the stack processor.
- Consumes the dp_inc / rp_inc codes driven each cycle by the multicycle control FSM.
- Feeds DP/RP to the memory address mux.
- Tracks stack depth and high-water marks, and detects overflow/underflow with a sticky fault that freezes both pointers until software clears it.

---
 rtl/stack_ptr_unit.sv | 152 +++++++++++++++
 tb/tb_stack_ptr_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/stack_ptr_unit.sv
// Data/return stack pointer unit for the stack processor: tracks DP/RP, depths,
// high-water marks, and raises a sticky overflow/underflow fault that freezes both stacks.
module stack_ptr_unit #(
  parameter int                ADDR_W  = 16,
  parameter int                STEP    = 2,
  parameter logic [ADDR_W-1:0] D_TOP   = 16'h7FFE,
  parameter int                D_DEPTH = 64,
  parameter logic [ADDR_W-1:0] R_TOP   = 16'hFFFE,
  parameter int                R_DEPTH = 32
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic [1:0]        dp_inc,
  input  logic [1:0]        rp_inc,
  input  logic              fault_clr,
  output logic [ADDR_W-1:0] dp,
  output logic [ADDR_W-1:0] rp,
  output logic [7:0]        d_depth,
  output logic [7:0]        r_depth,
  output logic [7:0]        d_hwm,
  output logic [7:0]        r_hwm,
  output logic              d_empty,
  output logic              d_full,
  output logic              r_empty,
  output logic              r_full,
  output logic              fault,
  output logic [2:0]        fault_code
);

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    FC_NONE  = 3'b000,
    FC_D_OVF = 3'b001,
    FC_D_UNF = 3'b010,
    FC_R_OVF = 3'b011,
    FC_R_UNF = 3'b100
  } fault_code_e;

  localparam logic [ADDR_W-1:0] STEP_A  = ADDR_W'(STEP);
  localparam logic [7:0]        D_CAP   = 8'(D_DEPTH);
  localparam logic [7:0]        R_CAP   = 8'(R_DEPTH);

  logic [ADDR_W-1:0] dp_q, rp_q, dp_d, rp_d;
  logic [7:0]        d_depth_q, r_depth_q, d_depth_d, r_depth_d;
  logic [7:0]        d_hwm_q, r_hwm_q, d_hwm_d, r_hwm_d;
  logic              fault_q, fault_d;
  fault_code_e       code_q, code_d;

  logic d_push, d_pop, r_push, r_pop;
  logic d_ovf, d_unf, r_ovf, r_unf, err, run;

  assign d_empty = (d_depth_q == 8'd0);
  assign d_full  = (d_depth_q == D_CAP);
  assign r_empty = (r_depth_q == 8'd0);
  assign r_full  = (r_depth_q == R_CAP);

  assign d_push = (dp_inc == OP_PUSH);
  assign d_pop  = (dp_inc == OP_POP);
  assign r_push = (rp_inc == OP_PUSH);
  assign r_pop  = (rp_inc == OP_POP);

  assign d_ovf = d_push && d_full;
  assign d_unf = d_pop  && d_empty;
  assign r_ovf = r_push && r_full;
  assign r_unf = r_pop  && r_empty;
  assign err   = d_ovf || d_unf || r_ovf || r_unf;
  // Any error, or an existing fault, suppresses every pointer move this cycle.
  assign run   = !fault_q && !err;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    dp_d      = dp_q;
    rp_d      = rp_q;
    d_depth_d = d_depth_q;
    r_depth_d = r_depth_q;
    if (run) begin
      if (d_push) begin
        dp_d      = dp_q - STEP_A;
        d_depth_d = d_depth_q + 8'd1;
      end else if (d_pop) begin
        dp_d      = dp_q + STEP_A;
        d_depth_d = d_depth_q - 8'd1;
      end
      if (r_push) begin
        rp_d      = rp_q - STEP_A;
        r_depth_d = r_depth_q + 8'd1;
      end else if (r_pop) begin
        rp_d      = rp_q + STEP_A;
        r_depth_d = r_depth_q - 8'd1;
      end
    end
    d_hwm_d = (d_depth_d > d_hwm_q) ? d_depth_d : d_hwm_q;
    r_hwm_d = (r_depth_d > r_hwm_q) ? r_depth_d : r_hwm_q;
  end

  // Fault is sticky: only a clear while faulted drops it; D errors take priority.
  always_comb begin
    fault_d = fault_q;
    code_d  = code_q;
    if (fault_q) begin
      if (fault_clr) begin
        fault_d = 1'b0;
        code_d  = FC_NONE;
      end
    end else if (err) begin
      fault_d = 1'b1;
      if (d_ovf)      code_d = FC_D_OVF;
      else if (d_unf) code_d = FC_D_UNF;
      else if (r_ovf) code_d = FC_R_OVF;
      else            code_d = FC_R_UNF;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      dp_q      <= D_TOP;
      rp_q      <= R_TOP;
      d_depth_q <= 8'd0;
      r_depth_q <= 8'd0;
      d_hwm_q   <= 8'd0;
      r_hwm_q   <= 8'd0;
      fault_q   <= 1'b0;
      code_q    <= FC_NONE;
    end else begin
      dp_q      <= dp_d;
      rp_q      <= rp_d;
      d_depth_q <= d_depth_d;
      r_depth_q <= r_depth_d;
      d_hwm_q   <= d_hwm_d;
      r_hwm_q   <= r_hwm_d;
      fault_q   <= fault_d;
      code_q    <= code_d;
    end
  end

  assign dp         = dp_q;
  assign rp         = rp_q;
  assign d_depth    = d_depth_q;
  assign r_depth    = r_depth_q;
  assign d_hwm      = d_hwm_q;
  assign r_hwm      = r_hwm_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_stack_ptr_unit.sv
// Directed bench for stack_ptr_unit: a vector table plus hand-built sequences
// for fill-to-overflow, dual errors, clear-cycle behaviour and reset.
module tb_stack_ptr_unit;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic [1:0]  dp_inc, rp_inc;
  logic        fault_clr;
  logic [15:0] dp, rp;
  logic [7:0]  d_depth, r_depth, d_hwm, r_hwm;
  logic        d_empty, d_full, r_empty, r_full, fault;
  logic [2:0]  fault_code;

  int checks   = 0;
  int failures = 0;

  stack_ptr_unit dut (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .dp_inc     (dp_inc),
    .rp_inc     (rp_inc),
    .fault_clr  (fault_clr),
    .dp         (dp),
    .rp         (rp),
    .d_depth    (d_depth),
    .r_depth    (r_depth),
    .d_hwm      (d_hwm),
    .r_hwm      (r_hwm),
    .d_empty    (d_empty),
    .d_full     (d_full),
    .r_empty    (r_empty),
    .r_full     (r_full),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rn;
    logic [1:0]  di;
    logic [1:0]  ri;
    logic        clr;
    logic [15:0] dp;
    logic [15:0] rp;
    logic [7:0]  dd;
    logic [7:0]  rd;
    logic [7:0]  dh;
    logic [7:0]  rh;
    logic        f;
    logic [2:0]  fc;
  } vec_t;

  function automatic vec_t mk(input logic rn, input logic [1:0] di, input logic [1:0] ri,
                              input logic clr, input logic [15:0] xdp, input logic [15:0] xrp,
                              input logic [7:0] dd, input logic [7:0] rd, input logic [7:0] dh,
                              input logic [7:0] rh, input logic f, input logic [2:0] fc);
    vec_t v;
    v.rn = rn; v.di = di; v.ri = ri; v.clr = clr;
    v.dp = xdp; v.rp = xrp; v.dd = dd; v.rd = rd; v.dh = dh; v.rh = rh;
    v.f = f; v.fc = fc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then compare every output plus the pointer/depth invariants.
  task automatic apply(input vec_t v, input string lbl);
    reset_n   = v.rn;
    dp_inc    = v.di;
    rp_inc    = v.ri;
    fault_clr = v.clr;
    @(posedge CLK);
    #1;
    check({lbl, ".dp"},         32'(dp),         32'(v.dp));
    check({lbl, ".rp"},         32'(rp),         32'(v.rp));
    check({lbl, ".d_depth"},    32'(d_depth),    32'(v.dd));
    check({lbl, ".r_depth"},    32'(r_depth),    32'(v.rd));
    check({lbl, ".d_hwm"},      32'(d_hwm),      32'(v.dh));
    check({lbl, ".r_hwm"},      32'(r_hwm),      32'(v.rh));
    check({lbl, ".fault"},      32'(fault),      32'(v.f));
    check({lbl, ".fault_code"}, 32'(fault_code), 32'(v.fc));
    check({lbl, ".d_empty"},    32'(d_empty),    32'(v.dd == 8'd0));
    check({lbl, ".d_full"},     32'(d_full),     32'(v.dd == 8'd64));
    check({lbl, ".r_empty"},    32'(r_empty),    32'(v.rd == 8'd0));
    check({lbl, ".r_full"},     32'(r_full),     32'(v.rd == 8'd32));
    check({lbl, ".inv_dp"},     32'(dp), 32'(16'h7FFE - 16'(2 * int'(d_depth))));
    check({lbl, ".inv_rp"},     32'(rp), 32'(16'hFFFE - 16'(2 * int'(r_depth))));
    check({lbl, ".inv_dcap"},   32'(d_depth <= 8'd64), 32'd1);
    check({lbl, ".inv_rcap"},   32'(r_depth <= 8'd32), 32'd1);
    check({lbl, ".inv_dhwm"},   32'(d_hwm >= d_depth), 32'd1);
    check({lbl, ".inv_rhwm"},   32'(r_hwm >= r_depth), 32'd1);
  endtask

  vec_t tbl [14];
  vec_t e;

  initial begin
    reset_n = 1'b0; dp_inc = 2'b00; rp_inc = 2'b00; fault_clr = 1'b0;

    //            rn  di     ri     clr  dp        rp        dd  rd  dh  rh  f  fc
    tbl[0]  = mk(0, 2'b00, 2'b00, 0, 16'h7FFE, 16'hFFFE, 0, 0, 0, 0, 0, 3'b000);
    tbl[1]  = mk(1, 2'b01, 2'b00, 0, 16'h7FFC, 16'hFFFE, 1, 0, 1, 0, 0, 3'b000);
    tbl[2]  = mk(1, 2'b01, 2'b00, 0, 16'h7FFA, 16'hFFFE, 2, 0, 2, 0, 0, 3'b000);
    tbl[3]  = mk(1, 2'b01, 2'b00, 0, 16'h7FF8, 16'hFFFE, 3, 0, 3, 0, 0, 3'b000);
    tbl[4]  = mk(1, 2'b00, 2'b01, 0, 16'h7FF8, 16'hFFFC, 3, 1, 3, 1, 0, 3'b000);
    tbl[5]  = mk(1, 2'b01, 2'b10, 0, 16'h7FF6, 16'hFFFE, 4, 0, 4, 1, 0, 3'b000);
    tbl[6]  = mk(1, 2'b11, 2'b11, 0, 16'h7FF6, 16'hFFFE, 4, 0, 4, 1, 0, 3'b000);
    tbl[7]  = mk(1, 2'b01, 2'b10, 0, 16'h7FF6, 16'hFFFE, 4, 0, 4, 1, 1, 3'b100);
    tbl[8]  = mk(1, 2'b01, 2'b01, 0, 16'h7FF6, 16'hFFFE, 4, 0, 4, 1, 1, 3'b100);
    tbl[9]  = mk(1, 2'b10, 2'b00, 1, 16'h7FF6, 16'hFFFE, 4, 0, 4, 1, 0, 3'b000);
    tbl[10] = mk(1, 2'b10, 2'b00, 0, 16'h7FF8, 16'hFFFE, 3, 0, 4, 1, 0, 3'b000);
    tbl[11] = mk(0, 2'b01, 2'b01, 0, 16'h7FFE, 16'hFFFE, 0, 0, 0, 0, 0, 3'b000);
    tbl[12] = mk(1, 2'b10, 2'b10, 0, 16'h7FFE, 16'hFFFE, 0, 0, 0, 0, 1, 3'b010);
    tbl[13] = mk(1, 2'b00, 2'b00, 1, 16'h7FFE, 16'hFFFE, 0, 0, 0, 0, 0, 3'b000);

    for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Fill the data stack, then overflow it.
    e = mk(1, 2'b01, 2'b00, 0, 16'h7FFE, 16'hFFFE, 0, 0, 0, 0, 0, 3'b000);
    for (int i = 1; i <= 64; i++) begin
      e.dp = 16'h7FFE - 16'(2 * i);
      e.dd = 8'(i);
      e.dh = 8'(i);
      apply(e, $sformatf("fill%0d", i));
    end
    e.f = 1'b1; e.fc = 3'b001;
    apply(e, "ovf65");
    e.di = 2'b10;
    for (int i = 0; i < 3; i++) apply(e, $sformatf("frozen_pop%0d", i));
    e.clr = 1'b1; e.f = 1'b0; e.fc = 3'b000;
    apply(e, "clr_cycle");
    e.clr = 1'b0; e.dp = 16'h7F80; e.dd = 8'd63;
    apply(e, "pop_after_clr");

    // Refill to full, then D overflow and R underflow together.
    e.di = 2'b01; e.dp = 16'h7F7E; e.dd = 8'd64;
    apply(e, "refill");
    e.ri = 2'b10; e.f = 1'b1; e.fc = 3'b001;
    apply(e, "dual_err");
    e.di = 2'b00; e.ri = 2'b00; e.clr = 1'b1; e.f = 1'b0; e.fc = 3'b000;
    apply(e, "dual_clr");

    // Clear request while not faulted loses to a new D underflow.
    e = mk(0, 2'b00, 2'b00, 0, 16'h7FFE, 16'hFFFE, 0, 0, 0, 0, 0, 3'b000);
    apply(e, "rst2");
    e.rn = 1'b1; e.di = 2'b10; e.clr = 1'b1; e.f = 1'b1; e.fc = 3'b010;
    apply(e, "clr_vs_unf");
    e.di = 2'b00; e.f = 1'b0; e.fc = 3'b000;
    apply(e, "clr_unf");
    e.clr = 1'b0;

    // Build depth 5, pop to 2, reset mid-sequence.
    e.di = 2'b01;
    for (int i = 1; i <= 5; i++) begin
      e.dp = 16'h7FFE - 16'(2 * i); e.dd = 8'(i); e.dh = 8'(i);
      apply(e, $sformatf("build%0d", i));
    end
    e.di = 2'b10;
    for (int i = 4; i >= 2; i--) begin
      e.dp = 16'h7FFE - 16'(2 * i); e.dd = 8'(i);
      apply(e, $sformatf("drain%0d", i));
    end
    e = mk(0, 2'b10, 2'b01, 0, 16'h7FFE, 16'hFFFE, 0, 0, 0, 0, 0, 3'b000);
    apply(e, "mid_reset");

    // Reserved codes hold a non-trivial state.
    e = mk(1, 2'b01, 2'b01, 0, 16'h7FFC, 16'hFFFC, 1, 1, 1, 1, 0, 3'b000);
    apply(e, "pre_hold");
    e.di = 2'b11; e.ri = 2'b11;
    for (int i = 0; i < 10; i++) apply(e, $sformatf("hold11_%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
